// File: rtl/p4s1_2_if.sv
// Frame-in / word-out bus for the 4:1 parallel-to-serial converter.
// The driver of frames and controls uses master; the converter uses slave.
interface p4s1_2_if #(
  parameter int WORDLENGTH = 16
);
  logic                  enable;
  logic                  load;
  logic [WORDLENGTH-1:0] data_in0;
  logic [WORDLENGTH-1:0] data_in1;
  logic [WORDLENGTH-1:0] data_in2;
  logic [WORDLENGTH-1:0] data_in3;
  logic                  ready;
  logic [WORDLENGTH-1:0] data_out;
  logic                  out_valid;
  logic [1:0]            counter_out;
  logic                  frame_last;
  logic                  overrun;

  modport master (
    output enable, load, data_in0, data_in1, data_in2, data_in3,
    input  ready, data_out, out_valid, counter_out, frame_last, overrun
  );

  modport slave (
    input  enable, load, data_in0, data_in1, data_in2, data_in3,
    output ready, data_out, out_valid, counter_out, frame_last, overrun
  );
endinterface

// File: rtl/p4s1_2.sv
// 4:1 parallel-to-serial converter: 4-word shifter plus one-frame hold buffer,
// emitting data_in3..data_in0 one word per enabled cycle, with a sticky overrun flag.
module p4s1_2 #(
  parameter int WORDLENGTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  p4s1_2_if.slave  bus
);
  typedef logic [WORDLENGTH-1:0] word_t;

  word_t       r_sh   [4];
  word_t       r_hold [4];
  logic [2:0]  r_rem;
  logic        r_hold_full;
  word_t       r_data_out;
  logic        r_out_valid;
  logic [1:0]  r_cnt;
  logic        r_last;
  logic        r_overrun;

  word_t       w_in       [4];
  word_t       w_sh_nxt   [4];
  word_t       w_hold_nxt [4];
  logic [2:0]  w_rem_nxt;
  logic        w_hold_full_nxt;
  logic        w_ready;
  logic        w_accept;
  logic        w_emit;
  logic        w_done_next;
  logic [1:0]  w_idx;

  // Slot 0 is emitted first, so the frame is stored in output order.
  assign w_in[0] = bus.data_in3;
  assign w_in[1] = bus.data_in2;
  assign w_in[2] = bus.data_in1;
  assign w_in[3] = bus.data_in0;

  assign w_ready     = ~r_hold_full;
  assign w_accept    = bus.load & w_ready;
  assign w_emit      = bus.enable & (r_rem != 3'd0);
  assign w_done_next = (r_rem == 3'd0) | ((r_rem == 3'd1) & bus.enable);
  // rem counts down 4..1, so the word index within the frame is 4 - rem.
  assign w_idx       = 2'(3'd4 - r_rem);

  always_comb begin
    w_sh_nxt        = r_sh;
    w_hold_nxt      = r_hold;
    w_rem_nxt       = r_rem;
    w_hold_full_nxt = r_hold_full;
    if (w_done_next) begin
      if (r_hold_full) begin
        w_sh_nxt        = r_hold;
        w_rem_nxt       = 3'd4;
        w_hold_full_nxt = w_accept;
        if (w_accept) w_hold_nxt = w_in;
      end else if (w_accept) begin
        w_sh_nxt  = w_in;
        w_rem_nxt = 3'd4;
      end else begin
        w_rem_nxt = 3'd0;
      end
    end else begin
      if (w_emit) w_rem_nxt = r_rem - 3'd1;
      if (w_accept) begin
        w_hold_nxt      = w_in;
        w_hold_full_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        r_sh[i]   <= '0;
        r_hold[i] <= '0;
      end
      r_rem       <= '0;
      r_hold_full <= 1'b0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sh        <= w_sh_nxt;
      r_hold      <= w_hold_nxt;
      r_rem       <= w_rem_nxt;
      r_hold_full <= w_hold_full_nxt;
      if (w_emit) begin
        r_data_out  <= r_sh[w_idx];
        r_cnt       <= w_idx;
        r_out_valid <= 1'b1;
        r_last      <= (w_idx == 2'd3);
      end else begin
        r_out_valid <= 1'b0;
        r_last      <= 1'b0;
      end
      if (bus.load & ~w_ready) r_overrun <= 1'b1;
    end
  end

  assign bus.ready       = w_ready;
  assign bus.data_out    = r_data_out;
  assign bus.out_valid   = r_out_valid;
  assign bus.counter_out = r_cnt;
  assign bus.frame_last  = r_last;
  assign bus.overrun     = r_overrun;
endmodule

// File: doc/p4s1_2.md
P4S1_2 -- requirements
Module: p4s1_2

Interface
REQ-001 SHALL have parameter WORDLENGTH, default 16, the width of every data word.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port enable  input  1  clock-enable for the output shifter.
REQ-005 SHALL have port load  input  1  request to accept one 4-word frame this cycle.
REQ-006 SHALL have ports data_in0..data_in3  input  WORDLENGTH each  parallel frame words.
REQ-007 SHALL have port ready  output  1  high when a load will be accepted this cycle.
REQ-008 SHALL have port data_out  output  WORDLENGTH  serial output word, registered.
REQ-009 SHALL have port out_valid  output  1  data_out holds a new word this cycle.
REQ-010 SHALL have port counter_out  output  2  index of data_out within its frame, 0..3.
REQ-011 SHALL have port frame_last  output  1  high with the last word of a frame.
REQ-012 SHALL have port overrun  output  1  sticky flag: a load was dropped.

Function
REQ-013 SHALL hold a 4-word shifter with a remaining-word count rem (0..4) and a 4-word hold buffer with flag hold_full.
REQ-014 SHALL drive ready = NOT hold_full, decoded from registers only.
REQ-015 SHALL define accept = load AND ready.
REQ-016 SHALL define done_next = (rem==0) OR (rem==1 AND enable).
REQ-017 SHALL, when done_next and hold_full, move hold into the shifter (rem=4), clear hold_full, and capture an accepted load into hold (hold_full=1).
REQ-018 SHALL, when done_next and not hold_full, load an accepted frame directly into the shifter (rem=4); with no accept, rem goes to 0 when it was 1.
REQ-019 SHALL, when not done_next, capture an accepted load into hold (hold_full=1).
REQ-020 SHALL, when enable=1 and rem>0, emit one word per cycle in the order data_in3, data_in2, data_in1, data_in0, registered on the next edge, with out_valid=1.
REQ-021 SHALL set counter_out to 0, 1, 2, 3 for those four words, and set frame_last=1 only with counter_out=3.
REQ-022 SHALL, when enable=0, freeze the shifter and rem, hold data_out and counter_out, and drive out_valid=0 and frame_last=0.
REQ-023 SHALL still accept loads while enable=0, per REQ-017 to REQ-019.
REQ-024 SHALL, when enable=1 and rem=0, hold data_out and drive out_valid=0.
REQ-025 SHALL place the first word on data_out one edge after the accepting edge when the shifter is empty.
REQ-026 SHALL, with enable held high and an accept every 4 cycles, keep out_valid continuously high with no bubbles.
REQ-027 SHALL, when load=1 and ready=0, leave all stored data unchanged and set overrun=1 until reset.

Reset
REQ-028 SHALL, while rst=0, asynchronously clear data_out, counter_out, out_valid, frame_last, overrun, rem, hold_full and all stored words to 0, which makes ready=1.
REQ-029 SHALL discard a frame that is partly emitted when reset is asserted; after release, the first output comes only from a new accept.

Verification
REQ-030 SHALL cover reset: rst=0 -> data_out=0, out_valid=0, counter_out=0, frame_last=0, overrun=0, ready=1.
REQ-031 SHALL cover a single frame: data_in0..3 = 0x0001..0x0004, load at edge k, enable=1 -> data_out = 0x0004, 0x0003, 0x0002, 0x0001 at edges k+1..k+4, counter_out 0..3, frame_last only at k+4.
REQ-032 SHALL cover streaming: accepts at k, k+4, k+8 -> out_valid high from k+1 through k+12 and 12 words in order.
REQ-033 SHALL cover a stall: enable=0 for 3 cycles after the second word -> data_out stays 0x0003, out_valid=0; then 0x0002 follows on resume.
REQ-034 SHALL cover overrun: loads on 3 consecutive cycles from empty -> the first frame goes to the shifter and the second to hold, ready=0 on the third, the third frame is dropped, overrun=1, and 8 words are output.
REQ-035 SHALL cover reset mid-frame: rst=0 after 2 words -> outputs cleared; after release with no load, out_valid stays 0.
